// File: rtl/sale_pkg.sv
// rtl/sale_pkg.sv - op codes, FSM states, widths and slot field offsets for the cart store
package sale_pkg;
  localparam int NUM_SLOTS = 12;
  localparam int CNT_W     = 4;
  localparam int PRICE_W   = 16;
  localparam int TOTAL_W   = 20;
  localparam int SLOT_W    = CNT_W + PRICE_W;
  localparam int BUS_W     = NUM_SLOTS * SLOT_W;
  localparam int IDX_W     = 4;

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

  typedef enum logic [1:0] {
    OP_ADD       = 2'b00,
    OP_REMOVE    = 2'b01,
    OP_SET_PRICE = 2'b10,
    OP_CLEAR     = 2'b11
  } op_e;

  typedef enum logic [1:0] {IDLE, UPDATE, SUM, DONE} state_e;

  // Slot 0 occupies the top of the bus, so slot k starts at bit 239-20k.
  function automatic int slot_lsb(input int k);
    return BUS_W - SLOT_W * (k + 1);
  endfunction
endpackage

// File: rtl/cart_mac.sv
// rtl/cart_mac.sv - saturating count*price accumulator, one product per cycle
module cart_mac
  import sale_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [CNT_W-1:0]   cnt_i,
  input  logic [PRICE_W-1:0] price_i,
  output logic [TOTAL_W-1:0] acc_next_o,
  output logic               ovf_next_o
);
  logic [TOTAL_W-1:0] acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [TOTAL_W-1:0] prod;
  logic [TOTAL_W:0]   sum;

  always_comb begin
    prod  = TOTAL_W'(cnt_i) * TOTAL_W'(price_i);
    sum   = {1'b0, acc_q} + {1'b0, prod};
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      if (sum[TOTAL_W]) begin
        acc_d = TOTAL_MAX;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[TOTAL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  // Next-state view lets the top publish the final sum on the same edge it is formed.
  assign acc_next_o = acc_d;
  assign ovf_next_o = ovf_d;
endmodule

// File: rtl/cart_register.sv
// rtl/cart_register.sv - cart store: slot registers, recompute FSM and bus packing
// Optional CART_VOID_EN: CLEAR zeroes every count instead of being rejected.
module cart_register
  import sale_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [3:0]         cmd_slot,
  input  logic [PRICE_W-1:0] cmd_price,
  output logic               cmd_done,
  output logic               cmd_err,
  output logic               total_ovf,
  output logic [BUS_W-1:0]   numbers,
  output logic [TOTAL_W-1:0] total_price
);
  state_e             state_q, state_d;
  op_e                op_q;
  logic [3:0]         slot_q;
  logic [PRICE_W-1:0] price_q;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   cnt_q [NUM_SLOTS];
  logic [CNT_W-1:0]   cnt_d [NUM_SLOTS];
  logic [PRICE_W-1:0] prc_q [NUM_SLOTS];
  logic [PRICE_W-1:0] prc_d [NUM_SLOTS];
  logic [TOTAL_W-1:0] total_q, acc_next;
  logic               ovf_q, ovf_next;
  logic               accept, last_sum, mac_clr, mac_en;

  assign accept   = cmd_valid && cmd_ready;
  assign last_sum = (state_q == SUM) && (idx_q == IDX_W'(NUM_SLOTS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = UPDATE;
      UPDATE:  state_d = SUM;
      SUM:     if (last_sum) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    cmd_done  = (state_q == DONE);
    cmd_err   = (state_q == DONE) && err_q;
    mac_clr   = (state_q == UPDATE);
    mac_en    = (state_q == SUM);
  end

  always_comb begin
    cnt_d = cnt_q;
    prc_d = prc_q;
    err_d = 1'b0;
    if (state_q == UPDATE) begin
      if (op_q == OP_CLEAR) begin
`ifdef CART_VOID_EN
        for (int k = 0; k < NUM_SLOTS; k++) cnt_d[k] = '0;
`else
        err_d = 1'b1;
`endif
      end else if (slot_q >= 4'(NUM_SLOTS)) begin
        err_d = 1'b1;
      end else begin
        case (op_q)
          OP_ADD:
            if (cnt_q[slot_q] == CNT_MAX) err_d = 1'b1;
            else cnt_d[slot_q] = cnt_q[slot_q] + CNT_W'(1);
          OP_REMOVE:
            if (cnt_q[slot_q] == '0) err_d = 1'b1;
            else cnt_d[slot_q] = cnt_q[slot_q] - CNT_W'(1);
          default: prc_d[slot_q] = price_q;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q    <= OP_ADD;
      slot_q  <= '0;
      price_q <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
        cnt_q[k] <= '0;
        prc_q[k] <= '0;
      end
    end else begin
      if (accept) begin
        op_q    <= op_e'(cmd_op);
        slot_q  <= cmd_slot;
        price_q <= cmd_price;
      end
      if (state_q == UPDATE) begin
        err_q <= err_d;
        idx_q <= '0;
      end else if (state_q == SUM) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (last_sum) begin
        total_q <= acc_next;
        ovf_q   <= ovf_next;
      end
      cnt_q <= cnt_d;
      prc_q <= prc_d;
    end
  end

  cart_mac u_mac (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (mac_clr),
    .en_i       (mac_en),
    .cnt_i      (cnt_q[idx_q]),
    .price_i    (prc_q[idx_q]),
    .acc_next_o (acc_next),
    .ovf_next_o (ovf_next)
  );

  always_comb begin
    numbers = '0;
    for (int k = 0; k < NUM_SLOTS; k++) numbers[slot_lsb(k) +: SLOT_W] = {cnt_q[k], prc_q[k]};
  end

  assign total_price = total_q;
  assign total_ovf   = ovf_q;
endmodule

// File: tb/tb_cart_register.sv
// tb/tb_cart_register.sv - directed self-checking bench for cart_register
module tb_cart_register;
  logic         CLK;
  logic         RST;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [3:0]   cmd_slot;
  logic [15:0]  cmd_price;
  logic         cmd_done;
  logic         cmd_err;
  logic         total_ovf;
  logic [239:0] numbers;
  logic [19:0]  total_price;

  int          checks = 0;
  int          errors = 0;
  int          lat;
  logic        got_err;
  logic [19:0] mid_total;
  logic        mid_ready;
  logic [19:0] exp_total;

  cart_register dut (
    .CLK         (CLK),
    .RST         (RST),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_slot    (cmd_slot),
    .cmd_price   (cmd_price),
    .cmd_done    (cmd_done),
    .cmd_err     (cmd_err),
    .total_ovf   (total_ovf),
    .numbers     (numbers),
    .total_price (total_price)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [19:0] field(input int k);
    return numbers[239 - 20 * k -: 20];
  endfunction

  task automatic send_cmd(input logic [1:0] op, input logic [3:0] slot, input logic [15:0] price);
    int guard;
    @(negedge CLK);
    cmd_op = op; cmd_slot = slot; cmd_price = price; cmd_valid = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    lat = 1;
    while (!cmd_done && lat < 40) begin
      if (lat == 7) begin
        mid_total = total_price;
        mid_ready = cmd_ready;
      end
      @(posedge CLK);
      @(negedge CLK);
      lat++;
    end
    got_err = cmd_err;
    checks++;
    if (cmd_done !== 1'b1) begin
      errors++;
      $display("FAIL cmd_done_timeout op=%0d slot=%0d waited %0d cycles", op, slot, lat);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_slot = 4'd0; cmd_price = 16'd0;
    repeat (3) @(negedge CLK);
    checks++; if (numbers !== 240'd0) begin errors++; $display("FAIL reset_numbers got %h exp 0", numbers); end
    checks++; if (total_price !== 20'd0) begin errors++; $display("FAIL reset_total got %h exp 0", total_price); end
    checks++; if ({cmd_done, cmd_err, total_ovf} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {cmd_done, cmd_err, total_ovf}); end
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_set_add();
    send_cmd(2'b10, 4'd0, 16'd250);
    checks++; if (lat !== 14) begin errors++; $display("FAIL set_latency got %0d exp 14", lat); end
    checks++; if (total_price !== 20'd0 || got_err !== 1'b0) begin errors++; $display("FAIL set_total got %0d err %b exp 0 err 0", total_price, got_err); end
    for (int i = 1; i <= 3; i++) begin
      send_cmd(2'b00, 4'd0, 16'd0);
      checks++; if (lat !== 14) begin errors++; $display("FAIL add_latency got %0d exp 14", lat); end
      checks++; if (total_price !== 20'(250 * i) || got_err !== 1'b0) begin
        errors++; $display("FAIL add_total got %0d err %b exp %0d err 0", total_price, got_err, 250 * i);
      end
    end
    checks++; if (mid_total !== 20'd500) begin errors++; $display("FAIL mid_sum_total got %0d exp 500", mid_total); end
    checks++; if (mid_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b exp 0", mid_ready); end
    checks++; if (field(0) !== {4'd3, 16'd250}) begin errors++; $display("FAIL slot0_field got %h exp %h", field(0), {4'd3, 16'd250}); end
  endtask

  task automatic test_clear();
    send_cmd(2'b11, 4'd0, 16'd0);
`ifdef CART_VOID_EN
    exp_total = 20'd0;
    checks++; if (got_err !== 1'b0) begin errors++; $display("FAIL clear_err got %b exp 0", got_err); end
    checks++; if (field(0) !== {4'd0, 16'd250}) begin errors++; $display("FAIL clear_field got %h exp %h", field(0), {4'd0, 16'd250}); end
`else
    exp_total = 20'd750;
    checks++; if (got_err !== 1'b1) begin errors++; $display("FAIL clear_err got %b exp 1", got_err); end
    checks++; if (field(0) !== {4'd3, 16'd250}) begin errors++; $display("FAIL clear_field got %h exp %h", field(0), {4'd3, 16'd250}); end
`endif
    checks++; if (total_price !== exp_total || total_ovf !== 1'b0) begin
      errors++; $display("FAIL clear_total got %0d ovf %b exp %0d ovf 0", total_price, total_ovf, exp_total);
    end
  endtask

  task automatic test_remove_empty();
    send_cmd(2'b01, 4'd5, 16'd0);
    checks++; if (got_err !== 1'b1) begin errors++; $display("FAIL remove_err got %b exp 1", got_err); end
    checks++; if (field(5) !== 20'd0) begin errors++; $display("FAIL remove_field got %h exp 0", field(5)); end
    checks++; if (total_price !== exp_total) begin errors++; $display("FAIL remove_total got %0d exp %0d", total_price, exp_total); end
  endtask

  task automatic test_add_saturate();
    int early_errs;
    logic last_err;
    early_errs = 0;
    last_err = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      send_cmd(2'b00, 4'd2, 16'd0);
      if (i < 16) early_errs += int'(got_err);
      else last_err = got_err;
    end
    checks++; if (early_errs !== 0) begin errors++; $display("FAIL sat_early_err got %0d exp 0", early_errs); end
    checks++; if (last_err !== 1'b1) begin errors++; $display("FAIL sat_16th_err got %b exp 1", last_err); end
    checks++; if (field(2) !== {4'd15, 16'd0}) begin errors++; $display("FAIL sat_field got %h exp %h", field(2), {4'd15, 16'd0}); end
  endtask

  task automatic test_overflow();
    for (int s = 0; s < 12; s++) begin
      send_cmd(2'b10, 4'(s), 16'hFFFF);
      repeat (15) send_cmd(2'b00, 4'(s), 16'd0);
      if (s == 0) begin
        checks++; if (total_price !== 20'd983025 || total_ovf !== 1'b0) begin
          errors++; $display("FAIL ovf_edge_total got %0d ovf %b exp 983025 ovf 0", total_price, total_ovf);
        end
      end
    end
    checks++; if (total_price !== 20'hFFFFF) begin errors++; $display("FAIL ovf_total got %h exp fffff", total_price); end
    checks++; if (total_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", total_ovf); end
    checks++; if (numbers !== {12{20'hFFFFF}}) begin errors++; $display("FAIL ovf_numbers got %h exp all f", numbers); end
  endtask

  task automatic test_bad_slot_reset();
    send_cmd(2'b00, 4'd12, 16'd0);
    checks++; if (got_err !== 1'b1) begin errors++; $display("FAIL bad_slot_err got %b exp 1", got_err); end
    checks++; if (numbers !== {12{20'hFFFFF}}) begin errors++; $display("FAIL bad_slot_numbers got %h exp all f", numbers); end
    checks++; if (total_price !== 20'hFFFFF) begin errors++; $display("FAIL bad_slot_total got %h exp fffff", total_price); end
    @(negedge CLK);
    cmd_op = 2'b00; cmd_slot = 4'd12; cmd_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    repeat (6) @(negedge CLK);
    RST = 1'b1;
    #1;
    checks++; if (numbers !== 240'd0 || total_price !== 20'd0) begin
      errors++; $display("FAIL midsum_reset_data got total %h exp 0", total_price);
    end
    checks++; if ({cmd_done, cmd_err, total_ovf} !== 3'b000) begin errors++; $display("FAIL midsum_reset_flags got %b exp 000", {cmd_done, cmd_err, total_ovf}); end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++; if (cmd_ready !== 1'b1 || cmd_done !== 1'b0) begin
      errors++; $display("FAIL midsum_release got ready %b done %b exp 1 0", cmd_ready, cmd_done);
    end
  endtask

  initial begin
    test_reset();
    test_set_add();
    test_clear();
    test_remove_empty();
    test_add_saturate();
    test_overflow();
    test_bad_slot_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
